// File: rtl/counter_checker.sv
// Passive sequence monitor for an up/down wrapping counter: predicts the next
// count from the shared control inputs, flags divergence and resynchronises.
module counter_checker #(
    parameter int COUNT_WIDTH   = 4,
    parameter int COUNT_START   = 2,
    parameter int COUNT_END     = 11,
    parameter int COUNT_STEP    = 2,
    parameter int ERR_WIDTH     = 8,
    parameter int RELOCK_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   up_down,
    input  logic                   load_en,
    input  logic [COUNT_WIDTH-1:0] load_count,
    input  logic [COUNT_WIDTH-1:0] count,
    output logic [COUNT_WIDTH-1:0] expected_count,
    output logic                   mismatch,
    output logic                   wrap,
    output logic [ERR_WIDTH-1:0]   err_count,
    output logic                   locked
);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam int MW = ($clog2(RELOCK_CYCLES + 1) < 1) ? 1 : $clog2(RELOCK_CYCLES + 1);

    localparam logic [COUNT_WIDTH:0]   START_X = (COUNT_WIDTH + 1)'(COUNT_START);
    localparam logic [COUNT_WIDTH:0]   END_X   = (COUNT_WIDTH + 1)'(COUNT_END);
    localparam logic [COUNT_WIDTH:0]   STEP_X  = (COUNT_WIDTH + 1)'(COUNT_STEP);
    localparam logic [COUNT_WIDTH:0]   LOW_X   = START_X + STEP_X;
    localparam logic [COUNT_WIDTH-1:0] START_V = COUNT_WIDTH'(COUNT_START);
    localparam logic [COUNT_WIDTH-1:0] END_V   = COUNT_WIDTH'(COUNT_END);
    localparam logic [COUNT_WIDTH-1:0] STEP_V  = COUNT_WIDTH'(COUNT_STEP);
    localparam logic [ERR_WIDTH-1:0]   ERR_MAX = {ERR_WIDTH{1'b1}};
    localparam logic [ERR_WIDTH-1:0]   ERR_ONE = ERR_WIDTH'(1);
    localparam logic [MW-1:0]          M_ONE   = MW'(1);
    localparam logic [MW-1:0]          M_LAST  = MW'(RELOCK_CYCLES - 1);

    // Returns {wrap, next value}; the step arithmetic is one bit wider so an
    // overflow past the top of the count range is seen as out of range.
    function automatic logic [COUNT_WIDTH:0] next_val(
        input logic [COUNT_WIDTH-1:0] v,
        input logic                   ld,
        input logic [COUNT_WIDTH-1:0] ldv,
        input logic                   e,
        input logic                   up
    );
        logic [COUNT_WIDTH:0] sum;
        logic [COUNT_WIDTH:0] res;
        sum = {1'b0, v} + STEP_X;
        if (ld) begin
            res = {1'b0, ldv};
        end else if (!e) begin
            res = {1'b0, v};
        end else if (up) begin
            if (sum > END_X) res = {1'b1, START_V};
            else             res = {1'b0, sum[COUNT_WIDTH-1:0]};
        end else begin
            if ({1'b0, v} < LOW_X) res = {1'b1, END_V};
            else                   res = {1'b0, v - STEP_V};
        end
        return res;
    endfunction

    logic [1:0]             state_q, state_d;
    logic [COUNT_WIDTH-1:0] exp_q, exp_d;
    logic                   mis_q, mis_d;
    logic                   wrap_q, wrap_d;
    logic [ERR_WIDTH-1:0]   err_q, err_d;
    logic [MW-1:0]          match_q, match_d;
    logic                   locked_q;
    logic                   diff_s;
    logic [COUNT_WIDTH-1:0] src_s;
    logic [COUNT_WIDTH:0]   nv_s;
    logic [ERR_WIDTH-1:0]   err_inc_s;

    assign diff_s    = (count != exp_q);
    assign err_inc_s = (err_q == ERR_MAX) ? err_q : (err_q + ERR_ONE);

    // Next-state, compare and prediction-source selection.
    always_comb begin
        state_d = state_q;
        mis_d   = 1'b0;
        err_d   = err_q;
        match_d = match_q;
        src_s   = exp_q;
        case (state_q)
            ST_INIT: begin
                state_d = ST_TRACK;
                match_d = {MW{1'b0}};
            end
            ST_TRACK: begin
                if (diff_s) begin
                    mis_d   = 1'b1;
                    err_d   = err_inc_s;
                    src_s   = count;
                    state_d = ST_FAULT;
                    match_d = {MW{1'b0}};
                end else begin
                    src_s = exp_q;
                end
            end
            ST_FAULT: begin
                src_s = count;
                if (diff_s) begin
                    mis_d   = 1'b1;
                    err_d   = err_inc_s;
                    match_d = {MW{1'b0}};
                end else if (match_q == M_LAST) begin
                    state_d = ST_TRACK;
                    match_d = {MW{1'b0}};
                end else begin
                    match_d = match_q + M_ONE;
                end
            end
            default: begin
                state_d = ST_INIT;
                match_d = {MW{1'b0}};
            end
        endcase
        nv_s   = next_val(src_s, load_en, load_count, en, up_down);
        wrap_d = nv_s[COUNT_WIDTH];
        exp_d  = nv_s[COUNT_WIDTH-1:0];
    end

    // State and registered outputs; reset takes effect without a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_INIT;
            exp_q    <= START_V;
            mis_q    <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= {ERR_WIDTH{1'b0}};
            match_q  <= {MW{1'b0}};
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            mis_q    <= mis_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
            match_q  <= match_d;
            locked_q <= (state_d == ST_TRACK);
        end
    end

    assign expected_count = exp_q;
    assign mismatch       = mis_q;
    assign wrap           = wrap_q;
    assign err_count      = err_q;
    assign locked         = locked_q;

endmodule

// File: tb/tb_counter_checker.sv
// Scoreboard bench for counter_checker: a behavioural reference pushes the
// expected outputs each cycle and each test pops and compares them.
module tb_counter_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up_down = 1'b1;
    logic       load_en = 1'b0;
    logic [3:0] load_count = 4'd0;
    logic [3:0] count = 4'd2;
    logic [3:0] count2 = 4'd3;
    logic [3:0] expected_count, expected_count2;
    logic       mismatch, wrap, locked, mismatch2, wrap2, locked2;
    logic [7:0] err_count;
    logic [1:0] err_count2;
    logic [14:0] obs_s;

    int n_cmp = 0;
    int n_err = 0;
    logic [14:0] sb[$];
    logic [14:0] exp_v;
    int m_state, m_exp, m_err, m_match;

    counter_checker dut (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load_en(load_en),
        .load_count(load_count), .count(count), .expected_count(expected_count),
        .mismatch(mismatch), .wrap(wrap), .err_count(err_count), .locked(locked)
    );

    counter_checker #(.ERR_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load_en(load_en),
        .load_count(load_count), .count(count2), .expected_count(expected_count2),
        .mismatch(mismatch2), .wrap(wrap2), .err_count(err_count2), .locked(locked2)
    );

    assign obs_s = {expected_count, mismatch, wrap, err_count, locked};

    always #5 clk = ~clk;

    function automatic int f_model(input int v, output bit w);
        w = 1'b0;
        if (load_en) return int'(load_count);
        if (!en) return v;
        if (up_down) begin
            if (v + 2 > 11) begin w = 1'b1; return 2; end
            return v + 2;
        end
        if (v < 4) begin w = 1'b1; return 11; end
        return v - 2;
    endfunction

    task automatic model_reset();
        m_state = 0; m_exp = 2; m_err = 0; m_match = 0;
        sb.delete();
    endtask

    // Predicts this edge's outcome, queues it, then advances one clock.
    task automatic drive_cycle();
        int  n;
        bit  w;
        bit  mis;
        int  cv;
        mis = 1'b0;
        cv  = int'(count);
        if (m_state == 0) begin
            n = f_model(m_exp, w);
            m_state = 1;
        end else if (cv != m_exp) begin
            mis = 1'b1;
            if (m_err < 255) m_err++;
            n = f_model(cv, w);
            m_state = 2;
            m_match = 0;
        end else begin
            n = f_model(cv, w);
            if (m_state == 2) begin
                m_match++;
                if (m_match >= 3) m_state = 1;
            end
        end
        m_exp = n;
        sb.push_back({4'(n), mis, w, 8'(m_err), (m_state == 1)});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (obs_s !== {4'd2, 1'b0, 1'b0, 8'd0, 1'b0}) begin
            n_err++; $display("FAIL reset_outputs: got %h want %h", obs_s, {4'd2, 1'b0, 1'b0, 8'd0, 1'b0});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_up();
        int seq[5] = '{4, 6, 8, 10, 2};
        en = 1'b1; up_down = 1'b1; load_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            count = 4'(m_exp);
            drive_cycle();
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs_s !== exp_v) begin n_err++; $display("FAIL up_sb[%0d]: got %h want %h", i, obs_s, exp_v); end
            n_cmp++;
            if (expected_count !== 4'(seq[i]) || wrap !== (i == 4) || mismatch !== 1'b0 || locked !== 1'b1) begin
                n_err++; $display("FAIL up_seq[%0d]: got exp=%0d wrap=%b mis=%b lock=%b want exp=%0d", i, expected_count, wrap, mismatch, locked, seq[i]);
            end
        end
    endtask

    task automatic test_down();
        int seq[6] = '{11, 9, 7, 5, 3, 11};
        up_down = 1'b0;
        for (int i = 0; i < 6; i++) begin
            count = 4'(m_exp);
            drive_cycle();
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs_s !== exp_v) begin n_err++; $display("FAIL down_sb[%0d]: got %h want %h", i, obs_s, exp_v); end
            n_cmp++;
            if (expected_count !== 4'(seq[i]) || wrap !== (i == 0 || i == 5) || mismatch !== 1'b0) begin
                n_err++; $display("FAIL down_seq[%0d]: got exp=%0d wrap=%b mis=%b want exp=%0d", i, expected_count, wrap, mismatch, seq[i]);
            end
        end
    endtask

    task automatic test_fault();
        int guard;
        up_down = 1'b1;
        guard = 0;
        while (m_exp != 6 && guard < 10) begin
            count = 4'(m_exp);
            drive_cycle();
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs_s !== exp_v) begin n_err++; $display("FAIL fault_pre_sb: got %h want %h", obs_s, exp_v); end
            guard++;
        end
        n_cmp++;
        if (expected_count !== 4'd6) begin n_err++; $display("FAIL fault_reach6: got %0d want 6", expected_count); end
        count = 4'd7;
        drive_cycle();
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs_s !== exp_v) begin n_err++; $display("FAIL fault_sb: got %h want %h", obs_s, exp_v); end
        n_cmp++;
        if (mismatch !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0 || expected_count !== 4'd9) begin
            n_err++; $display("FAIL fault_hit: got mis=%b err=%0d lock=%b exp=%0d want 1 1 0 9", mismatch, err_count, locked, expected_count);
        end
        for (int i = 0; i < 3; i++) begin
            count = 4'(m_exp);
            drive_cycle();
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs_s !== exp_v) begin n_err++; $display("FAIL relock_sb[%0d]: got %h want %h", i, obs_s, exp_v); end
            n_cmp++;
            if (locked !== (i == 2) || mismatch !== 1'b0) begin
                n_err++; $display("FAIL relock[%0d]: got lock=%b mis=%b want lock=%b", i, locked, mismatch, (i == 2));
            end
        end
    endtask

    task automatic test_load();
        int seq[5] = '{5, 7, 9, 11, 2};
        en = 1'b1; up_down = 1'b1;
        for (int i = 0; i < 5; i++) begin
            load_en = (i == 0); load_count = 4'd5;
            count = 4'(m_exp);
            drive_cycle();
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs_s !== exp_v) begin n_err++; $display("FAIL load_sb[%0d]: got %h want %h", i, obs_s, exp_v); end
            n_cmp++;
            if (expected_count !== 4'(seq[i]) || wrap !== (i == 4)) begin
                n_err++; $display("FAIL load_seq[%0d]: got exp=%0d wrap=%b want exp=%0d", i, expected_count, wrap, seq[i]);
            end
        end
        // load during a mismatch, then out-of-range values both directions
        load_en = 1'b1; load_count = 4'd14; count = 4'd0;
        drive_cycle();
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs_s !== exp_v || expected_count !== 4'd14 || mismatch !== 1'b1 || wrap !== 1'b0) begin
            n_err++; $display("FAIL load_on_mis: got %h want %h", obs_s, exp_v);
        end
        load_en = 1'b0; count = 4'd14;
        drive_cycle();
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs_s !== exp_v || expected_count !== 4'd2 || wrap !== 1'b1) begin
            n_err++; $display("FAIL load_oor_up: got %h want %h", obs_s, exp_v);
        end
        load_en = 1'b1; load_count = 4'd0; count = 4'd2;
        drive_cycle();
        load_en = 1'b0; up_down = 1'b0; count = 4'd0;
        drive_cycle();
        void'(sb.pop_front());
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs_s !== exp_v || expected_count !== 4'd11 || wrap !== 1'b1) begin
            n_err++; $display("FAIL load_oor_down: got %h want %h", obs_s, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            en         = ($urandom_range(0, 4) != 0);
            up_down    = $urandom_range(0, 1) == 1;
            load_en    = ($urandom_range(0, 7) == 0);
            load_count = 4'($urandom_range(0, 15));
            count      = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'(m_exp);
            drive_cycle();
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs_s !== exp_v) begin n_err++; $display("FAIL random_sb[%0d]: got %h want %h", i, obs_s, exp_v); end
        end
        load_en = 1'b0;
    endtask

    task automatic test_async_reset();
        en = 1'b1; up_down = 1'b1;
        for (int i = 0; i < 3; i++) begin
            count = 4'(m_exp);
            drive_cycle();
            void'(sb.pop_front());
        end
        #2; rst = 1'b0; #1;
        n_cmp++;
        if (obs_s !== {4'd2, 1'b0, 1'b0, 8'd0, 1'b0}) begin
            n_err++; $display("FAIL async_reset: got %h want %h", obs_s, {4'd2, 1'b0, 1'b0, 8'd0, 1'b0});
        end
        #1; rst = 1'b1;
        model_reset();
        count = 4'd2;
        drive_cycle();
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs_s !== exp_v || expected_count !== 4'd4 || locked !== 1'b1) begin
            n_err++; $display("FAIL async_resume: got %h want %h", obs_s, exp_v);
        end
    endtask

    task automatic test_saturation();
        #2; rst = 1'b0; #1; rst = 1'b1;
        model_reset();
        en = 1'b1; up_down = 1'b1; load_en = 1'b0; count2 = 4'd3;
        for (int i = 0; i < 7; i++) begin
            count = 4'(m_exp);
            drive_cycle();
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs_s !== exp_v) begin n_err++; $display("FAIL sat_main_sb[%0d]: got %h want %h", i, obs_s, exp_v); end
            n_cmp++;
            if (mismatch2 !== (i >= 1) || err_count2 !== 2'((i > 3) ? 3 : i)) begin
                n_err++; $display("FAIL sat_err[%0d]: got mis=%b err=%0d want mis=%b err=%0d", i, mismatch2, err_count2, (i >= 1), (i > 3) ? 3 : i);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_up();
        test_down();
        test_fault();
        test_load();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Passive sequence checker that sits beside a `counter` instance and watches its `count` output.
- Mirrors the same control inputs (`en`, `up_down`, `load_en`, `load_count`) to predict the next expected value, and compares it with the observed count every cycle.
- Reports mismatches, keeps a saturating error tally and resynchronises to the observed value after a fault.
- Used in-system as a safety monitor and in benches as a self-checking scoreboard.

Parameters:
- COUNT_WIDTH, 4, width of observed and expected count.
- COUNT_START, 2, reset value and wrap target when counting up.
- COUNT_END, 11, wrap target when counting down; highest legal value.
- COUNT_STEP, 2, increment/decrement per enabled cycle.
- ERR_WIDTH, 8, width of the saturating error counter.
- RELOCK_CYCLES, 3, consecutive matches required to leave FAULT.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-low reset.
- en, in, 1, counter enable (same signal driving the monitored counter).
- up_down, in, 1, 1 = count up, 0 = count down.
- load_en, in, 1, load request; has priority over en.
- load_count, in, COUNT_WIDTH, load value.
- count, in, COUNT_WIDTH, observed counter output.
- expected_count, out, COUNT_WIDTH, value `count` must hold this cycle.
- mismatch, out, 1, one-cycle pulse on compare failure.
- wrap, out, 1, one-cycle pulse when the prediction wraps.
- err_count, out, ERR_WIDTH, saturating mismatch total.
- locked, out, 1, high in TRACK state.

Behaviour:
- Reset:
  - Clock and reset: single clock `clk`; reset `rst` is asynchronous and active-low.
  - While rst=0, all of the following hold immediately, without waiting for a clock edge: state=INIT, expected_count=COUNT_START, mismatch=0, wrap=0, err_count=0, locked=0.
- Next-value function f(v), evaluated in this priority order:
  - load_en=1 → load_count.
  - en=0 → v.
  - up_down=1 → if v+COUNT_STEP (computed COUNT_WIDTH+1 bits wide) > COUNT_END then COUNT_START, else v+COUNT_STEP.
  - up_down=0 → if v < COUNT_START+COUNT_STEP (COUNT_WIDTH+1 bits wide) then COUNT_END, else v-COUNT_STEP.
  - `wrap` is asserted the next cycle whenever either wrap branch is taken. A load never asserts wrap.
- Compare timing:
  - At each rising edge, `count` is compared with the registered expected_count.
  - The result is registered, so `mismatch` is high in the cycle after the bad sample.
- State machine:
  - INIT: compare skipped for one edge; exp <= f(exp); go to TRACK.
  - TRACK (locked=1):
    - Match → exp <= f(exp).
    - Mismatch → mismatch pulse, err_count+1, exp <= f(count), go to FAULT.
  - FAULT (locked=0):
    - Mismatches keep pulsing and counting; exp <= f(count) every cycle, resyncing to the observed value.
    - A match counter tracks consecutive matches and clears on any mismatch.
    - RELOCK_CYCLES consecutive matches → TRACK.
- Error counter: err_count saturates at all-ones; it never wraps.
- Loads: when load_en is high in the same cycle as a mismatch, the load value wins for the next expected value.
- Out-of-range values: loaded values outside [COUNT_START, COUNT_END] are tracked as given. The following step applies the same wrap rule.
- Reset mid-operation: state returns to INIT immediately, and err_count clears.

Test Plan:
- Up counting: rst released, en=1, up_down=1, counter conforming → count 2,4,6,8,10,2; mismatch never set; wrap pulses once at the 10→2 step; locked=1 from the 2nd cycle.
- Down counting: from 2 with up_down=0 → expected 11,9,7,5,3,11; wrap on 2→11 and 3→11; no mismatch.
- Fault and relock: force count=7 while expected=6 → mismatch pulse next cycle, err_count=1, locked=0. The next expected value is f(7)=9. After 3 conforming cycles locked=1.
- Load: load_en=1, load_count=5 with en=1 → expected_count=5 next cycle (load beats step), no wrap; then 7,9,11,2.
- Saturation: ERR_WIDTH=2 with persistent mismatch for 6 cycles → err_count 1,2,3,3,3,3; mismatch high every cycle.
- Async reset: assert rst=0 mid-count, between clock edges → outputs go to reset values before the next edge; count resumes at 2 after release.
